// File: rtl/fetch_pc_stage.sv
// IF stage: owns the PC, selects the next PC, fetches over a req/ack instruction port
// and drives the IF/ID pipeline register under hazard-unit stall/flush control.
module fetch_pc_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_instr
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] fetch_addr_q;
   logic [31:0] buf_q;
   logic        ifid_valid_q;
   logic [31:0] ifid_pc_q;
   logic [31:0] ifid_pc4_q;
   logic [31:0] ifid_instr_q;

   logic        redir;
   logic [31:0] redir_raw;
   logic [31:0] redir_tgt;
   logic [31:0] pc_plus4;
   logic [31:0] fetch_plus4;

   // A redirect is only honoured when ID is not stalled; ID re-asserts it later.
   assign redir     = (jr | jmp | br_taken) & ~stall;
   assign redir_raw = jr ? jr_target : (jmp ? jmp_target : br_target);
   assign redir_tgt = {redir_raw[31:2], 2'b00};

   assign pc_plus4    = pc_q + 32'd4;
   assign fetch_plus4 = fetch_addr_q + 32'd4;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         fetch_addr_q <= 32'h0;
         buf_q        <= 32'h0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= 32'h0;
         ifid_pc4_q   <= 32'h0;
         ifid_instr_q <= 32'h0;
      end else begin
         // ID consumed its instruction unless stalled; later loads override this bubble.
         if (!stall) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= 32'h0;
         end

         unique case (state_q)
            StIdle: begin
               state_q      <= StFetch;
               fetch_addr_q <= pc_q;
               if (redir) begin
                  pc_q         <= redir_tgt;
                  fetch_addr_q <= redir_tgt;
               end
            end

            StFetch: begin
               if (imem_ack) begin
                  if (redir) begin
                     pc_q         <= redir_tgt;
                     fetch_addr_q <= redir_tgt;
                  end else if (stall) begin
                     buf_q   <= imem_rdata;
                     state_q <= StHold;
                  end else begin
                     ifid_valid_q <= 1'b1;
                     ifid_pc_q    <= fetch_addr_q;
                     ifid_pc4_q   <= fetch_plus4;
                     ifid_instr_q <= imem_rdata;
                     pc_q         <= pc_plus4;
                     fetch_addr_q <= pc_plus4;
                  end
               end else if (redir) begin
                  // Request is in flight; keep its address until the stale ack returns.
                  pc_q    <= redir_tgt;
                  state_q <= StDrain;
               end
            end

            StHold: begin
               if (!stall) begin
                  state_q <= StFetch;
                  if (redir) begin
                     pc_q         <= redir_tgt;
                     fetch_addr_q <= redir_tgt;
                  end else begin
                     ifid_valid_q <= 1'b1;
                     ifid_pc_q    <= fetch_addr_q;
                     ifid_pc4_q   <= fetch_plus4;
                     ifid_instr_q <= buf_q;
                     pc_q         <= pc_plus4;
                     fetch_addr_q <= pc_plus4;
                  end
               end
            end

            StDrain: begin
               if (redir) begin
                  pc_q <= redir_tgt;
               end
               if (imem_ack) begin
                  state_q      <= StFetch;
                  fetch_addr_q <= redir ? redir_tgt : pc_q;
               end
            end

            default: state_q <= StIdle;
         endcase

         if (flush) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= 32'h0;
         end
      end
   end

   assign imem_req   = (state_q == StFetch) || (state_q == StDrain);
   assign imem_addr  = fetch_addr_q;
   assign pc         = pc_q;
   assign ifid_valid = ifid_valid_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_pc4   = ifid_pc4_q;
   assign ifid_instr = ifid_instr_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage; memory returns addr ^ 32'hA5A5_A5A5.
module tb_fetch_pc_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        jr;
   logic [31:0] jr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_instr;

   int checks = 0;
   int errors = 0;

   fetch_pc_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .flush      (flush),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .jr         (jr),
      .jr_target  (jr_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .pc         (pc),
      .ifid_valid (ifid_valid),
      .ifid_pc    (ifid_pc),
      .ifid_pc4   (ifid_pc4),
      .ifid_instr (ifid_instr)
   );

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
      br_taken = 1'b0; br_target = 32'h0;
      jmp = 1'b0; jmp_target = 32'h0;
      jr = 1'b0; jr_target = 32'h0;

      // Reset
      tick(); tick();
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'b0, ifid_valid}, 32'd0);
      check("rst_ifid_pc4", ifid_pc4, 32'h0);
      rst_n = 1'b1;
      tick();
      check("idle_to_fetch_req", {31'b0, imem_req}, 32'd1);
      check("idle_to_fetch_addr", imem_addr, 32'h0);
      check("idle_valid", {31'b0, ifid_valid}, 32'd0);

      // Back-to-back fetches
      imem_ack = 1'b1;
      tick();
      check("seq0_pc", ifid_pc, 32'h0);
      check("seq0_instr", ifid_instr, 32'hA5A5_A5A5);
      check("seq0_valid", {31'b0, ifid_valid}, 32'd1);
      check("seq0_pc4", ifid_pc4, 32'h4);
      tick();
      check("seq1_pc", ifid_pc, 32'h4);
      check("seq1_instr", ifid_instr, 32'hA5A5_A5A1);
      tick();
      check("seq2_pc", ifid_pc, 32'h8);
      check("seq2_instr", ifid_instr, 32'hA5A5_A5AD);
      tick();
      check("seq3_pc", ifid_pc, 32'hC);
      check("seq3_instr", ifid_instr, 32'hA5A5_A5A9);
      check("seq3_next_addr", imem_addr, 32'h10);

      // Restart and stall on the ack at pc=8
      imem_ack = 1'b0; rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      imem_ack = 1'b1;
      tick(); tick();
      check("pre_stall_pc", pc, 32'h8);
      stall = 1'b1;
      tick();
      imem_ack = 1'b0;
      check("hold_req", {31'b0, imem_req}, 32'd0);
      check("hold_ifid_pc", ifid_pc, 32'h4);
      check("hold_valid", {31'b0, ifid_valid}, 32'd1);
      tick();
      check("hold2_ifid_pc", ifid_pc, 32'h4);
      tick();
      check("hold3_req", {31'b0, imem_req}, 32'd0);
      check("hold3_instr", ifid_instr, 32'hA5A5_A5A1);
      stall = 1'b0;
      tick();
      check("release_ifid_pc", ifid_pc, 32'h8);
      check("release_instr", ifid_instr, 32'hA5A5_A5AD);
      check("release_addr", imem_addr, 32'hC);
      check("release_req", {31'b0, imem_req}, 32'd1);

      // Branch while the request to 0x10 is outstanding
      imem_ack = 1'b1;
      tick();
      check("pre_br_addr", imem_addr, 32'h10);
      imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h40;
      tick();
      br_taken = 1'b0;
      check("drain_pc", pc, 32'h40);
      check("drain_addr", imem_addr, 32'h10);
      check("drain_req", {31'b0, imem_req}, 32'd1);
      check("drain_valid", {31'b0, ifid_valid}, 32'd0);
      check("drain_instr", ifid_instr, 32'h0);
      tick();
      check("drain2_addr", imem_addr, 32'h10);
      imem_ack = 1'b1;
      tick();
      check("drained_addr", imem_addr, 32'h40);
      check("drained_valid", {31'b0, ifid_valid}, 32'd0);
      tick();
      check("br_ifid_pc", ifid_pc, 32'h40);
      check("br_instr", ifid_instr, 32'hA5A5_A5E5);

      // jr beats jmp; low target bits cleared
      jr = 1'b1; jr_target = 32'h83; jmp = 1'b1; jmp_target = 32'h100;
      tick();
      jr = 1'b0; jmp = 1'b0;
      check("jr_pc", pc, 32'h80);
      check("jr_addr", imem_addr, 32'h80);
      check("jr_valid", {31'b0, ifid_valid}, 32'd0);
      tick();
      check("jr_ifid_pc", ifid_pc, 32'h80);
      check("jr_instr", ifid_instr, 32'hA5A5_A525);
      imem_ack = 1'b0; stall = 1'b1; flush = 1'b1;
      tick();
      stall = 1'b0; flush = 1'b0;
      check("flush_valid", {31'b0, ifid_valid}, 32'd0);
      check("flush_instr", ifid_instr, 32'h0);
      check("flush_pc", pc, 32'h84);

      // PC wrap at the top of the address space
      jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
      tick();
      jmp = 1'b0; imem_ack = 1'b1;
      tick();
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_pc", pc, 32'h0);
      check("wrap_ifid_pc4", ifid_pc4, 32'h0);
      check("wrap_instr", ifid_instr, 32'h5A5A_5A59);

      // Reset in the middle of a drain; a coincident ack is ignored
      imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h200;
      tick();
      br_taken = 1'b0;
      check("pre_rst_pc", pc, 32'h200);
      rst_n = 1'b0; imem_ack = 1'b1;
      tick();
      check("midrst_pc", pc, 32'h0);
      check("midrst_req", {31'b0, imem_req}, 32'd0);
      check("midrst_valid", {31'b0, ifid_valid}, 32'd0);
      rst_n = 1'b1; imem_ack = 1'b0;
      tick();
      check("postrst_req", {31'b0, imem_req}, 32'd1);
      check("postrst_addr", imem_addr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
